bcd_timer: RTL and testbench
============================

BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on tick_in (minimum 2).
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tick_in  input  1  divided square wave from the clock divider stage (nominal 1 Hz), treated as asynchronous level.
REQ-005 start  input  1  start or resume counting (level sampled each clk).
REQ-006 stop  input  1  pause counting.
REQ-007 clear  input  1  zero the count and return to IDLE.
REQ-008 load  input  1  load preset from load_min/load_sec.
REQ-009 mode  input  1  0 = count up, 1 = count down; sampled only on the start accept cycle.
REQ-010 load_min, load_sec  input  8 each  BCD preset value: [7:4] tens, [3:0] units.
REQ-011 min_bcd, sec_bcd  output  8 each  current count in BCD.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 tick_in SHALL pass through SYNC_STAGES flops plus one history flop; tick_p = last_sync & ~history, one clk wide per tick_in rising edge.
REQ-015 With SYNC_STAGES=2, a count SHALL change on the 3rd clk edge after the first edge that samples tick_in high.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and DONE.
REQ-017 Input priority SHALL be clear > load > stop > start on each cycle.
REQ-018 IDLE: start -> RUN (mode latched); load -> stay IDLE with preset applied.
REQ-019 RUN: stop -> PAUSE; each tick_p updates the count per the latched mode.
REQ-020 PAUSE: start -> RUN (mode re-latched); load applies the preset and stays in PAUSE.
REQ-021 DONE: start -> RUN; load -> IDLE with preset applied.
REQ-022 From any state, clear -> IDLE with count 00:00.
REQ-023 load in RUN SHALL be ignored.
REQ-024 Up mode: sec units 9->0 carries to sec tens; sec 59->00 carries to minutes; 59:59 wraps to 00:00 and counting continues in RUN.
REQ-025 Down mode: sec 00 borrows from minutes -> 59; a tick_p at 00:00 SHALL enter DONE with the count held at 00:00.
REQ-026 A start accepted in down mode with the count at 00:00 SHALL enter DONE on the next edge instead of RUN.
REQ-027 A tick_p coincident with an accepted stop or clear SHALL NOT change the count.
REQ-028 A tick_p coincident with start accepted from IDLE, PAUSE or DONE SHALL NOT change the count; counting begins with the next tick_p.
REQ-029 A preset is invalid if any units digit > 9, sec tens > 5, or min tens > 5; an invalid preset SHALL be ignored with no count or state change.
REQ-030 min_bcd and sec_bcd SHALL always hold valid BCD in the range 00..59.
REQ-031 running and done SHALL be registered decodes of the state, updating on the same edge as the state.

Reset
REQ-032 Asserting rst SHALL immediately, without a clk edge, force state IDLE, count 00:00, running=0, done=0, and clear all synchronizer and history flops.
REQ-033 A tick_in that is high at rst release SHALL NOT produce tick_p until tick_in falls and rises again.
REQ-034 rst asserted mid-RUN SHALL discard the count and the latched mode.

Verification
REQ-035 Up count: reset, start with mode=0, apply 61 tick_in rising edges -> 01:01, running=1; check the 3-cycle tick latency.
REQ-036 Up wrap: load 59:58 in IDLE, start up, apply 3 ticks -> 00:01, still RUN.
REQ-037 Down count: load 00:02, start down, apply 2 ticks -> 00:00, still RUN; apply 1 more tick -> DONE, done=1, count held at 00:00.
REQ-038 Pause and priority:
- In RUN, raise stop on the same cycle as tick_p -> count unchanged, PAUSE.
- Assert start with stop -> remains PAUSE.
- Assert clear with load -> IDLE, 00:00.
REQ-039 Invalid load: load 6A:00 or 12:60 -> count and state unchanged.
- load 12:34 during RUN -> ignored.
- start down at 00:00 -> DONE next cycle.
REQ-040 Async reset: assert rst between clk edges during RUN at 07:30 -> outputs read 00:00, IDLE immediately.
- Release rst with tick_in held high -> no count change until tick_in's next rising edge.

Source files
------------

// File: rtl/bcd_timer.sv
// -----------------------------------------------------------------------------
// bcd_timer -- mm:ss stopwatch / countdown timer counting in BCD.
//
// A slow square wave (tick_in, nominally 1 Hz, asynchronous to clk) is
// synchronised and edge-detected into a one-clk tick pulse. Each tick advances
// the mm:ss count (up or down, mode latched when counting starts) while the
// controller is in RUN. Counting down through 00:00 lands in DONE.
//
// Ports:
//   clk               system clock, all logic on the rising edge
//   rst               asynchronous, active-high reset
//   tick_in           asynchronous tick square wave
//   start/stop        run / pause controls (levels sampled every clk)
//   clear             zero the count and return to IDLE
//   load              apply load_min:load_sec preset (ignored while running)
//   mode              0 = up, 1 = down; latched only when a start is accepted
//   load_min/load_sec BCD preset, [7:4] tens, [3:0] units
//   min_bcd/sec_bcd   current count in BCD, always 00..59
//   running / done    registered decodes of RUN / DONE
//
// Input priority each cycle: clear > load > stop > start.
// -----------------------------------------------------------------------------
module bcd_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic       mode,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Tick synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;   // marks when sync_q holds real samples
  logic                   hist_q;
  logic                   armed_q;  // a genuine low level has been seen
  logic                   tick_p;

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= sync_q[SYNC_STAGES-1];
      // A tick_in already high at reset release must not look like an edge:
      // only arm once the synchroniser has delivered a real low sample.
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) armed_q <= 1'b1;
    end
  end

  assign tick_p = sync_q[SYNC_STAGES-1] & ~hist_q & armed_q;

  // ---------------------------------------------------------------------------
  // BCD mm:ss arithmetic, t = {min_tens, min_units, sec_tens, sec_units}
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] time_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd5) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          r[15:12] = (r[15:12] != 4'd5) ? r[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  // Never called with 00:00; that case is handled as the DONE transition.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          r[15:12] = (r[15:12] != 4'd0) ? r[15:12] - 4'd1 : 4'd5;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // {min_bcd, sec_bcd}
  logic        mode_q, mode_d;
  logic        running_q, done_q;
  logic        preset_ok;
  logic        cnt_zero;

  assign preset_ok = (load_min[7:4] <= 4'd5) && (load_min[3:0] <= 4'd9) &&
                     (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign cnt_zero  = (cnt_q == 16'h0000);

  always_comb begin
    // NOTE: every next-state signal takes a hold default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = 16'h0000;
    end else if (load && state_q != S_RUN) begin
      // The load branch claims the cycle even for a bad preset, so an
      // invalid load also blocks a simultaneous stop/start.
      if (preset_ok) begin
        cnt_d = {load_min, load_sec};
        if (state_q == S_DONE) state_d = S_IDLE;
      end
    end else if (stop) begin
      // stop wins over start in every state; it only acts in RUN.
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (start && state_q != S_RUN) begin
      // Accepted start swallows a coincident tick; counting begins next tick.
      mode_d  = mode;
      state_d = (mode && cnt_zero) ? S_DONE : S_RUN;
    end else if (state_q == S_RUN && tick_p) begin
      if (!mode_q)        cnt_d   = time_inc(cnt_q);
      else if (cnt_zero)  state_d = S_DONE;
      else                cnt_d   = time_dec(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'h0000;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      // Decoded from the next state so the flags change on the same edge.
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign min_bcd = cnt_q[15:8];
  assign sec_bcd = cnt_q[7:0];
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer -- self-checking bench for bcd_timer.
// Directed scenarios check fixed expected values; a randomized phase drives
// mixed commands and ticks against a reference model that keeps the time as
// a plain count of seconds and converts to BCD only for comparison.
// -----------------------------------------------------------------------------
module tb_bcd_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       start, stop, clear, load, mode;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done;
  logic [17:0] obs;

  int total = 0;
  int bad   = 0;

  bcd_timer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .mode     (mode),
    .load_min (load_min),
    .load_sec (load_sec),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign obs = {min_bcd, sec_bcd, running, done};

  // ---------------------------------------------------------------------------
  // Reference model: time as total seconds, state as a small integer
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs;
  int m_state;
  bit m_down;

  function automatic logic [17:0] exp_out();
    logic [17:0] e;
    e[17:14] = 4'(m_secs / 600);
    e[13:10] = 4'((m_secs / 60) % 10);
    e[9:6]   = 4'((m_secs % 60) / 10);
    e[5:2]   = 4'(m_secs % 10);
    e[1]     = (m_state == M_RUN);
    e[0]     = (m_state == M_DONE);
    return e;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_state = M_IDLE; m_down = 0;
  endtask

  task automatic model_tick();
    if (m_state == M_RUN) begin
      if (!m_down)          m_secs = (m_secs + 1) % 3600;
      else if (m_secs == 0) m_state = M_DONE;
      else                  m_secs = m_secs - 1;
    end
  endtask

  task automatic model_cmd(input bit s, input bit p, input bit c, input bit l,
                           input bit md, input logic [7:0] lm, input logic [7:0] ls);
    int mt, mu, st, su;
    mt = int'(lm[7:4]); mu = int'(lm[3:0]); st = int'(ls[7:4]); su = int'(ls[3:0]);
    if (c) begin
      m_state = M_IDLE; m_secs = 0;
    end else if (l && m_state != M_RUN) begin
      if (mt <= 5 && mu <= 9 && st <= 5 && su <= 9) begin
        m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
        if (m_state == M_DONE) m_state = M_IDLE;
      end
    end else if (p) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (s && m_state != M_RUN) begin
      m_down  = md;
      m_state = (md && m_secs == 0) ? M_DONE : M_RUN;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    start = 0; stop = 0; clear = 0; load = 0;
  endtask

  // One-cycle command pulse; returns at the falling edge after it was sampled.
  task automatic cmd(input bit s, input bit p, input bit c, input bit l,
                     input bit md, input logic [7:0] lm, input logic [7:0] ls);
    @(negedge clk);
    start = s; stop = p; clear = c; load = l; mode = md;
    load_min = lm; load_sec = ls;
    @(negedge clk);
    drive_idle();
  endtask

  // Full tick_in pulse; the count has moved by the time this returns.
  task automatic do_tick();
    @(negedge clk); tick_in = 1'b1;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // tick_in pulse with a command asserted exactly in the tick_p cycle.
  task automatic tick_with(input bit s, input bit p, input bit c, input bit md);
    @(negedge clk); tick_in = 1'b1;
    repeat (2) @(negedge clk);
    start = s; stop = p; clear = c; mode = md;
    @(negedge clk);
    drive_idle();
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #3;
    total++;
    if (obs !== 18'h0) begin
      bad++; $display("FAIL reset_state: got %h want %h", obs, 18'h0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_up_count();
    do_reset();
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL up_start: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    // First edge that samples tick_in high, then the next two.
    @(negedge clk); tick_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL latency_edge1: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL latency_edge2: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    total++;
    if (obs !== {8'h00, 8'h01, 1'b1, 1'b0}) begin
      bad++; $display("FAIL latency_edge3: got %h want %h", obs, {8'h00, 8'h01, 1'b1, 1'b0});
    end
    @(negedge clk); tick_in = 1'b0;
    repeat (3) @(negedge clk);
    repeat (60) do_tick();
    total++;
    if (obs !== {8'h01, 8'h01, 1'b1, 1'b0}) begin
      bad++; $display("FAIL up_61_ticks: got %h want %h", obs, {8'h01, 8'h01, 1'b1, 1'b0});
    end
  endtask

  task automatic test_up_wrap();
    do_reset();
    cmd(0, 0, 0, 1, 0, 8'h59, 8'h58);
    total++;
    if (obs !== {8'h59, 8'h58, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wrap_load: got %h want %h", obs, {8'h59, 8'h58, 1'b0, 1'b0});
    end
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    repeat (2) do_tick();
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_zero: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h01, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_continue: got %h want %h", obs, {8'h00, 8'h01, 1'b1, 1'b0});
    end
  endtask

  task automatic test_down_count();
    do_reset();
    cmd(0, 0, 0, 1, 0, 8'h00, 8'h02);
    cmd(1, 0, 0, 0, 1, 8'h00, 8'h00);
    total++;
    if (obs !== {8'h00, 8'h02, 1'b1, 1'b0}) begin
      bad++; $display("FAIL down_start: got %h want %h", obs, {8'h00, 8'h02, 1'b1, 1'b0});
    end
    repeat (2) do_tick();
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL down_reach_zero: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL down_done: got %h want %h", obs, {8'h00, 8'h00, 1'b0, 1'b1});
    end
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL done_held: got %h want %h", obs, {8'h00, 8'h00, 1'b0, 1'b1});
    end
    cmd(0, 0, 0, 1, 0, 8'h10, 8'h00);
    total++;
    if (obs !== {8'h10, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL done_load_idle: got %h want %h", obs, {8'h10, 8'h00, 1'b0, 1'b0});
    end
    // Borrow across the minute boundary: 10:00 -> 09:59.
    cmd(1, 0, 0, 0, 1, 8'h00, 8'h00);
    do_tick();
    total++;
    if (obs !== {8'h09, 8'h59, 1'b1, 1'b0}) begin
      bad++; $display("FAIL down_borrow: got %h want %h", obs, {8'h09, 8'h59, 1'b1, 1'b0});
    end
  endtask

  task automatic test_pause_priority();
    do_reset();
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    repeat (2) do_tick();
    tick_with(0, 1, 0, 0);
    total++;
    if (obs !== {8'h00, 8'h02, 1'b0, 1'b0}) begin
      bad++; $display("FAIL stop_with_tick: got %h want %h", obs, {8'h00, 8'h02, 1'b0, 1'b0});
    end
    cmd(1, 1, 0, 0, 0, 8'h00, 8'h00);
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h02, 1'b0, 1'b0}) begin
      bad++; $display("FAIL start_and_stop: got %h want %h", obs, {8'h00, 8'h02, 1'b0, 1'b0});
    end
    tick_with(1, 0, 0, 0);
    total++;
    if (obs !== {8'h00, 8'h02, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resume_with_tick: got %h want %h", obs, {8'h00, 8'h02, 1'b1, 1'b0});
    end
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h03, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resume_count: got %h want %h", obs, {8'h00, 8'h03, 1'b1, 1'b0});
    end
    cmd(0, 1, 0, 0, 0, 8'h00, 8'h00);
    cmd(0, 0, 1, 1, 0, 8'h12, 8'h34);
    total++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clear_over_load: got %h want %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    do_tick();
    tick_with(0, 0, 1, 0);
    total++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clear_with_tick: got %h want %h", obs, {8'h00, 8'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_invalid_load();
    do_reset();
    cmd(0, 0, 0, 1, 0, 8'h05, 8'h10);
    cmd(0, 0, 0, 1, 0, 8'h6A, 8'h00);
    total++;
    if (obs !== {8'h05, 8'h10, 1'b0, 1'b0}) begin
      bad++; $display("FAIL invalid_6A00: got %h want %h", obs, {8'h05, 8'h10, 1'b0, 1'b0});
    end
    cmd(0, 0, 0, 1, 0, 8'h12, 8'h60);
    total++;
    if (obs !== {8'h05, 8'h10, 1'b0, 1'b0}) begin
      bad++; $display("FAIL invalid_1260: got %h want %h", obs, {8'h05, 8'h10, 1'b0, 1'b0});
    end
    // An invalid load with a start in the same cycle blocks the start too.
    cmd(1, 0, 0, 1, 0, 8'h09, 8'h0A);
    total++;
    if (obs !== {8'h05, 8'h10, 1'b0, 1'b0}) begin
      bad++; $display("FAIL invalid_blocks_start: got %h want %h", obs, {8'h05, 8'h10, 1'b0, 1'b0});
    end
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    cmd(0, 0, 0, 1, 0, 8'h12, 8'h34);
    total++;
    if (obs !== {8'h05, 8'h10, 1'b1, 1'b0}) begin
      bad++; $display("FAIL load_in_run: got %h want %h", obs, {8'h05, 8'h10, 1'b1, 1'b0});
    end
    cmd(0, 0, 1, 0, 0, 8'h00, 8'h00);
    cmd(1, 0, 0, 0, 1, 8'h00, 8'h00);
    total++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL start_down_zero: got %h want %h", obs, {8'h00, 8'h00, 1'b0, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cmd(0, 0, 0, 1, 0, 8'h07, 8'h30);
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    total++;
    if (obs !== {8'h07, 8'h30, 1'b1, 1'b0}) begin
      bad++; $display("FAIL pre_reset_run: got %h want %h", obs, {8'h07, 8'h30, 1'b1, 1'b0});
    end
    // Assert between edges; outputs must clear before the next rising edge.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== 18'h0) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs, 18'h0);
    end
    tick_in = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
    repeat (6) @(negedge clk);
    total++;
    if (obs !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL tick_high_at_release: got %h want %h", obs, {8'h00, 8'h00, 1'b1, 1'b0});
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    do_tick();
    total++;
    if (obs !== {8'h00, 8'h01, 1'b1, 1'b0}) begin
      bad++; $display("FAIL first_tick_after_release: got %h want %h", obs, {8'h00, 8'h01, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    int         op;
    bit         s, p, l, md;
    logic [7:0] lm, ls;
    do_reset();
    model_reset();
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 9));
      md = 1'($urandom_range(0, 1));
      lm = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      ls = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      if ($urandom_range(0, 1) == 1) lm = 8'h00;  // keep countdowns short
      case (op)
        0, 1, 2: begin do_tick(); model_tick(); end
        3: begin cmd(1, 0, 0, 0, md, 8'h00, 8'h00); model_cmd(1, 0, 0, 0, md, 8'h00, 8'h00); end
        4: begin cmd(0, 1, 0, 0, md, 8'h00, 8'h00); model_cmd(0, 1, 0, 0, md, 8'h00, 8'h00); end
        5: begin cmd(0, 0, 0, 1, md, lm, ls); model_cmd(0, 0, 0, 1, md, lm, ls); end
        6: begin
          s = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
          cmd(s, p, 1, l, md, lm, ls); model_cmd(s, p, 1, l, md, lm, ls);
        end
        7: begin
          tick_with(1, 0, 0, md);
          if (m_state == M_RUN) model_tick();
          else model_cmd(1, 0, 0, 0, md, 8'h00, 8'h00);
        end
        8: begin tick_with(0, 1, 0, md); model_cmd(0, 1, 0, 0, md, 8'h00, 8'h00); end
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL random_step%0d_op%0d: got %h want %h", i, op, obs, exp_out());
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    tick_in  = 1'b0;
    mode     = 1'b0;
    load_min = 8'h00;
    load_sec = 8'h00;
    drive_idle();
    model_reset();
    test_reset();
    test_up_count();
    test_up_wrap();
    test_down_count();
    test_pause_priority();
    test_invalid_load();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
